// File: rtl/ring_counter_param_if.sv
// Control/status bundle for ring_counter_param: step/load controls in, counter state and pulses out.
interface ring_counter_param_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_data;
  logic             mode;
  logic             dir;
  logic [WIDTH-1:0] q;
  logic             wrap;
  logic             err;

  modport master (
    output en, load, load_data, mode, dir,
    input  q, wrap, err
  );

  modport slave (
    input  en, load, load_data, mode, dir,
    output q, wrap, err
  );
endinterface

// File: rtl/ring_counter_param.sv
// Parametrised ring / Johnson shift counter with load, direction control,
// registered wrap pulse and self-correction of illegal states.
module ring_counter_param #(
  parameter int               WIDTH         = 8,
  parameter logic [WIDTH-1:0] RESET_PATTERN = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input logic                 clk,
  input logic                 reset,
  ring_counter_param_if.slave bus
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("ring_counter_param: WIDTH must be in 2..32");
  end

  if ($countones(RESET_PATTERN) != 1) begin : g_bad_pattern
    $error("ring_counter_param: RESET_PATTERN must be one-hot");
  end

  logic [WIDTH-1:0] q_r;
  logic             wrap_r;
  logic             err_r;
  logic [WIDTH-1:0] step_q;
  logic [WIDTH-1:0] home;
  logic [WIDTH-2:0] trans;
  logic             legal;

  // home doubles as the correction target: RESET_PATTERN in ring, zeros in Johnson
  always_comb begin
    trans = q_r[WIDTH-1:1] ^ q_r[WIDTH-2:0];
    if (bus.mode) begin
      legal  = ($countones(trans) <= 1);
      home   = '0;
      step_q = bus.dir ? {q_r[WIDTH-2:0], ~q_r[WIDTH-1]}
                       : {~q_r[0], q_r[WIDTH-1:1]};
    end else begin
      legal  = ($countones(q_r) == 1);
      home   = RESET_PATTERN;
      step_q = bus.dir ? {q_r[WIDTH-2:0], q_r[WIDTH-1]}
                       : {q_r[0], q_r[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r    <= RESET_PATTERN;
      wrap_r <= 1'b0;
      err_r  <= 1'b0;
    end else if (bus.load) begin
      q_r    <= bus.load_data;
      wrap_r <= 1'b0;
      err_r  <= 1'b0;
    end else if (bus.en && !legal) begin
      q_r    <= home;
      wrap_r <= 1'b0;
      err_r  <= 1'b1;
    end else if (bus.en) begin
      q_r    <= step_q;
      wrap_r <= (step_q == home);
      err_r  <= 1'b0;
    end else begin
      wrap_r <= 1'b0;
      err_r  <= 1'b0;
    end
  end

  assign bus.q    = q_r;
  assign bus.wrap = wrap_r;
  assign bus.err  = err_r;

endmodule

// File: tb/tb_ring_counter_param.sv
// Scoreboard bench for ring_counter_param (WIDTH=4, RESET_PATTERN=0001): driver queues
// hand-computed {q,wrap,err} per edge, monitor pops and compares after each rising edge.
module tb_ring_counter_param;

  typedef struct {
    string      name;
    logic [5:0] v;
  } exp_t;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  ring_counter_param_if #(.WIDTH(4)) bus ();

  ring_counter_param #(
    .WIDTH(4),
    .RESET_PATTERN(4'b0001)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got q=%b wrap=%b err=%b, expected q=%b wrap=%b err=%b",
               name, act[5:2], act[1], act[0], expv[5:2], expv[1], expv[0]);
    end
  endtask

  // Drive one edge's inputs at the falling edge and queue the response for the next rising edge.
  task automatic step(input string name, input logic rst, input logic en, input logic ld,
                      input logic [3:0] ldd, input logic md, input logic dr,
                      input logic [3:0] eq, input logic ew, input logic ee);
    exp_t e;
    @(negedge clk);
    reset         = rst;
    bus.en        = en;
    bus.load      = ld;
    bus.load_data = ldd;
    bus.mode      = md;
    bus.dir       = dr;
    e.name = name;
    e.v    = {eq, ew, ee};
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.name, {bus.q, bus.wrap, bus.err}, e.v);
      end
    end
  end

  initial begin : driver
    int budget;
    reset         = 1'b1;
    bus.en        = 1'b0;
    bus.load      = 1'b0;
    bus.load_data = 4'b0000;
    bus.mode      = 1'b0;
    bus.dir       = 1'b0;
    #2;
    check("reset_state", {bus.q, bus.wrap, bus.err}, {4'b0001, 1'b0, 1'b0});

    // en and load are ignored while reset is high
    step("rst_hold_a", 1, 1, 1, 4'b1111, 0, 0, 4'b0001, 0, 0);
    step("rst_hold_b", 1, 1, 0, 4'b0000, 0, 0, 4'b0001, 0, 0);

    step("ring_r1", 0, 1, 0, 4'b0000, 0, 0, 4'b1000, 0, 0);
    step("ring_r2", 0, 1, 0, 4'b0000, 0, 0, 4'b0100, 0, 0);
    step("ring_r3", 0, 1, 0, 4'b0000, 0, 0, 4'b0010, 0, 0);
    step("ring_r4", 0, 1, 0, 4'b0000, 0, 0, 4'b0001, 1, 0);

    step("ring_l1", 0, 1, 0, 4'b0000, 0, 1, 4'b0010, 0, 0);
    step("ring_l2", 0, 1, 0, 4'b0000, 0, 1, 4'b0100, 0, 0);
    step("ring_l3", 0, 1, 0, 4'b0000, 0, 1, 4'b1000, 0, 0);
    step("ring_l4", 0, 1, 0, 4'b0000, 0, 1, 4'b0001, 1, 0);
    for (int i = 0; i < 3; i++)
      step("hold", 0, 0, 0, 4'b0000, 0, 1, 4'b0001, 0, 0);

    step("load_zero", 0, 0, 1, 4'b0000, 1, 0, 4'b0000, 0, 0);
    step("john_r1", 0, 1, 0, 4'b0000, 1, 0, 4'b1000, 0, 0);
    step("john_r2", 0, 1, 0, 4'b0000, 1, 0, 4'b1100, 0, 0);
    step("john_r3", 0, 1, 0, 4'b0000, 1, 0, 4'b1110, 0, 0);
    step("john_r4", 0, 1, 0, 4'b0000, 1, 0, 4'b1111, 0, 0);
    step("john_r5", 0, 1, 0, 4'b0000, 1, 0, 4'b0111, 0, 0);
    step("john_r6", 0, 1, 0, 4'b0000, 1, 0, 4'b0011, 0, 0);
    step("john_r7", 0, 1, 0, 4'b0000, 1, 0, 4'b0001, 0, 0);
    step("john_r8", 0, 1, 0, 4'b0000, 1, 0, 4'b0000, 1, 0);
    step("john_l1", 0, 1, 0, 4'b0000, 1, 1, 4'b0001, 0, 0);
    step("john_l2", 0, 1, 0, 4'b0000, 1, 1, 4'b0011, 0, 0);

    step("load_0110", 0, 0, 1, 4'b0110, 0, 0, 4'b0110, 0, 0);
    step("ring_fix", 0, 1, 0, 4'b0000, 0, 0, 4'b0001, 0, 1);
    step("ring_after_fix", 0, 1, 0, 4'b0000, 0, 0, 4'b1000, 0, 0);

    step("load_0101", 0, 0, 1, 4'b0101, 1, 0, 4'b0101, 0, 0);
    step("john_fix", 0, 1, 0, 4'b0000, 1, 0, 4'b0000, 0, 1);
    step("load_0011", 0, 0, 1, 4'b0011, 1, 0, 4'b0011, 0, 0);
    step("mode_switch_fix", 0, 1, 0, 4'b0000, 0, 0, 4'b0001, 0, 1);
    step("after_switch", 0, 1, 0, 4'b0000, 0, 0, 4'b1000, 0, 0);

    step("load_beats_en", 0, 1, 1, 4'b0100, 0, 0, 4'b0100, 0, 0);
    step("idle", 0, 0, 0, 4'b0000, 0, 0, 4'b0100, 0, 0);

    // async reset between edges
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reset", {bus.q, bus.wrap, bus.err}, {4'b0001, 1'b0, 1'b0});
    step("rst_held_en", 1, 1, 0, 4'b0000, 0, 0, 4'b0001, 0, 0);
    step("first_after_rst", 0, 1, 0, 4'b0000, 0, 0, 4'b1000, 0, 0);
    step("final_hold", 0, 0, 0, 4'b0000, 0, 0, 4'b1000, 0, 0);

    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
